// File: rtl/cpu_control_unit_if.sv
// Memory and ALU port bundle for the accumulator CPU control unit.
interface cpu_control_unit_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;

    modport master (
        output mem_addr, mem_wdata, mem_we, alu_op, alu_a, alu_b,
        input  mem_rdata, alu_result
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, alu_op, alu_a, alu_b,
        output mem_rdata, alu_result
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT; otherwise they run as NOPs.
module cpu_control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    cpu_control_unit_if.master    bus,
    output logic [15:0]           pc,
    output logic [15:0]           ac,
    output logic [15:0]           ir,
    output logic                  halted,
    output logic                  illegal,
    output logic                  instr_done
);
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC1, S_EXEC2, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ac_q, ac_d;
    logic [15:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic        done_q, done_d;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    logic [3:0]  opcode;
    logic [15:0] ea;
    logic        skip;

    assign opcode = ir_q[15:12];
    assign ea     = {4'h0, ir_q[11:0]};

    // SKIPCOND condition on signed ac
    always_comb begin
        unique case (ir_q[11:10])
            2'b00:   skip = ac_q[15];
            2'b01:   skip = (ac_q == 16'h0000);
            2'b10:   skip = !ac_q[15] && (ac_q != 16'h0000);
            default: skip = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ac_q      <= 16'h0000;
            ir_q      <= 16'h0000;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ac_q      <= ac_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ac_d         = ac_q;
        ir_d         = ir_q;
        halted_d     = halted_q;
        done_d       = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        bus.mem_addr = pc_q;
        bus.mem_we   = 1'b0;
        bus.alu_op   = ALU_ADD;

        unique case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = bus.mem_rdata;
                pc_d    = pc_q + 16'd1;
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                state_d = S_FETCH;
                done_d  = 1'b1;
                unique case (opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: begin
                        bus.mem_addr = ea;
                        done_d       = 1'b0;
                        state_d      = S_EXEC2;
                    end
                    OP_STORE: begin
                        bus.mem_addr = ea;
                        bus.mem_we   = 1'b1;
                    end
                    OP_JUMP:  pc_d = ea;
                    OP_CLEAR: ac_d = 16'h0000;
                    OP_SKIP:  if (skip) pc_d = pc_q + 16'd1;
                    OP_HALT: begin
                        done_d   = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        done_d    = 1'b0;
                        illegal_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = S_HALT;
`endif
                    end
                endcase
            end
            S_EXEC2: begin
                if (opcode == OP_SUBT) bus.alu_op = ALU_SUB;
                ac_d    = (opcode == OP_LOAD) ? bus.mem_rdata : bus.alu_result;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    halted_d  = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_wdata = ac_q;
    assign bus.alu_a     = ac_q;
    assign bus.alu_b     = bus.mem_rdata;

    assign pc         = pc_q;
    assign ac         = ac_q;
    assign ir         = ir_q;
    assign halted     = halted_q;
    assign instr_done = done_q;
`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal    = illegal_q;
`else
    assign illegal    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench: short programs run on two instances (RESET_PC 0000 and FFFF).
module tb_cpu_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, reset2 = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    logic [15:0] pc, ac, ir, pc2, ac2, ir2;
    logic halted, illegal, instr_done, halted2, illegal2, instr_done2;

    cpu_control_unit_if bus ();
    cpu_control_unit_if bus2 ();

    cpu_control_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .pc(pc), .ac(ac), .ir(ir), .halted(halted), .illegal(illegal),
        .instr_done(instr_done)
    );

    cpu_control_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .bus(bus2),
        .pc(pc2), .ac(ac2), .ir(ir2), .halted(halted2), .illegal(illegal2),
        .instr_done(instr_done2)
    );

    // Memory models with a bench-side load port, plus reference ALUs
    logic [15:0] mem1 [65536];
    logic [15:0] mem2 [65536];
    logic        ld_en = 1'b0, ld_sel = 1'b0;
    logic [15:0] ld_addr = 16'h0, ld_data = 16'h0;

    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem1[ld_addr] <= ld_data;
        else if (bus.mem_we) mem1[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem1[bus.mem_addr];
    end
    always @(posedge clk) begin
        if (ld_en && ld_sel) mem2[ld_addr] <= ld_data;
        else if (bus2.mem_we) mem2[bus2.mem_addr] <= bus2.mem_wdata;
        bus2.mem_rdata <= mem2[bus2.mem_addr];
    end
    assign bus.alu_result  = (bus.alu_op == 4'b0001) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
    assign bus2.alu_result = (bus2.alu_op == 4'b0001) ? bus2.alu_a - bus2.alu_b : bus2.alu_a + bus2.alu_b;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic poke(input logic sel, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_sel = sel; ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Counts cycles and retire pulses until halted, bounded
    task automatic wait_halt(output int cyc, output int dones);
        cyc = 0; dones = 0;
        while (!halted && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (instr_done) dones++;
        end
        check("halt_reached", 16'(halted), 16'h1);
    endtask

    task automatic wait_done2(input string name);
        int n = 0;
        while (!instr_done2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 16'(instr_done2), 16'h1);
    endtask

    typedef struct {
        logic [15:0] i0, i1, i2, data;
        logic [15:0] ac;
        logic [15:0] pc;
        int          done;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] ac;
        logic [15:0] pc;
        int          done;
        logic        ill;
    } exp_t;

    exp_t sb [$];
    localparam int unsigned NVEC = 15;
    vec_t vecs [NVEC];

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int cyc, dn;
        @(negedge clk);
        reset = 1'b1;
        poke(1'b0, 16'h0000, v.i0);
        poke(1'b0, 16'h0001, v.i1);
        poke(1'b0, 16'h0002, v.i2);
        poke(1'b0, 16'h0003, 16'h7000);
        poke(1'b0, 16'h0004, 16'h7000);
        poke(1'b0, 16'h0020, v.data);
        poke(1'b0, 16'h0021, 16'h0005);
        @(negedge clk);
        reset = 1'b0;
        e.ac = v.ac; e.pc = v.pc; e.done = v.done; e.ill = v.ill;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_halt(cyc, dn);
        e = sb.pop_front();
        check($sformatf("v%0d_ac", idx), ac, e.ac);
        check($sformatf("v%0d_pc", idx), pc, e.pc);
        check($sformatf("v%0d_done", idx), 16'(dn), 16'(e.done));
        check($sformatf("v%0d_illegal", idx), 16'(illegal), 16'(e.ill));
    endtask

    initial begin
        int cyc, dn;
        vecs[0]  = '{16'h1020, 16'h8000, 16'hA000, 16'hFFFE, 16'hFFFE, 16'h0004, 2, 1'b0};
        vecs[1]  = '{16'h1020, 16'h8000, 16'hA000, 16'h0001, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[2]  = '{16'h1020, 16'h8000, 16'hA000, 16'h0000, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[3]  = '{16'h1020, 16'h8400, 16'hA000, 16'h0000, 16'h0000, 16'h0004, 2, 1'b0};
        vecs[4]  = '{16'h1020, 16'h8400, 16'hA000, 16'h0005, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[5]  = '{16'h1020, 16'h8800, 16'hA000, 16'h0005, 16'h0005, 16'h0004, 2, 1'b0};
        vecs[6]  = '{16'h1020, 16'h8800, 16'hA000, 16'h8000, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[7]  = '{16'h1020, 16'h8C00, 16'hA000, 16'h8000, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[8]  = '{16'h1020, 16'h8C00, 16'hA000, 16'h0000, 16'h0000, 16'h0004, 3, 1'b0};
        vecs[9]  = '{16'h1020, 16'h3021, 16'h2022, 16'h8001, 16'h8006, 16'h0004, 3, 1'b0};
        vecs[10] = '{16'h1020, 16'h4021, 16'h8000, 16'h0003, 16'hFFFE, 16'h0005, 3, 1'b0};
        vecs[11] = '{16'h1020, 16'h9004, 16'hA000, 16'h1234, 16'h1234, 16'h0005, 2, 1'b0};
        vecs[12] = '{16'h1020, 16'hA000, 16'h3021, 16'h0009, 16'h0005, 16'h0004, 3, 1'b0};
        vecs[13] = '{16'h1020, 16'h4021, 16'h4021, 16'h0007, 16'hFFFD, 16'h0004, 3, 1'b0};
`ifdef CU_ILLEGAL_TRAP_EN
        vecs[14] = '{16'h1020, 16'hF000, 16'h3021, 16'h0002, 16'h0002, 16'h0002, 1, 1'b1};
`else
        vecs[14] = '{16'h1020, 16'hF000, 16'h3021, 16'h0002, 16'h0007, 16'h0004, 3, 1'b0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 16'h0000);
        check("rst_ac", ac, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_flags", {13'h0, halted, illegal, instr_done}, 16'h0);
        check("rst_we", 16'(bus.mem_we), 16'h0);
        check("rst_alu_op", 16'(bus.alu_op), 16'h0);
        check("rst_pc2", pc2, 16'hFFFF);

        for (int i = 0; i < int'(NVEC); i++) run_vec(i, vecs[i]);

`ifdef CU_ILLEGAL_TRAP_EN
        // Restart after trap resumes at the instruction following the illegal one
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("trap_clear_halted", 16'(halted), 16'h0);
        check("trap_clear_illegal", 16'(illegal), 16'h0);
        wait_halt(cyc, dn);
        check("trap_resume_ac", ac, 16'h0007);
        check("trap_resume_pc", pc, 16'h0004);
        check("trap_resume_done", 16'(dn), 16'h1);
`endif

        // LOAD/ADD/STORE program with cycle count from FETCH to halted
        @(negedge clk);
        reset = 1'b1;
        poke(1'b0, 16'h0000, 16'h1010);
        poke(1'b0, 16'h0001, 16'h3011);
        poke(1'b0, 16'h0002, 16'h2012);
        poke(1'b0, 16'h0003, 16'h7000);
        poke(1'b0, 16'h0010, 16'h0005);
        poke(1'b0, 16'h0011, 16'h0007);
        poke(1'b0, 16'h0012, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        wait_halt(cyc, dn);
        start = 1'b0;
        check("las_cycles", 16'(cyc), 16'd14);
        check("las_done", 16'(dn), 16'd3);
        check("las_ac", ac, 16'h000C);
        check("las_pc", pc, 16'h0004);
        check("las_mem12", mem1[16'h0012], 16'h000C);

        // Reset asserted while STORE is in EXEC1
        @(negedge clk);
        reset = 1'b1;
        poke(1'b0, 16'h0000, 16'h1020);
        poke(1'b0, 16'h0001, 16'h2030);
        poke(1'b0, 16'h0020, 16'h00AA);
        poke(1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!bus.mem_we && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("st_we_seen", 16'(bus.mem_we), 16'h1);
        check("st_addr", bus.mem_addr, 16'h0030);
        check("st_wdata", bus.mem_wdata, 16'h00AA);
        reset = 1'b1;
        #1;
        check("st_rst_we", 16'(bus.mem_we), 16'h0);
        check("st_rst_pc", pc, 16'h0000);
        check("st_rst_ac", ac, 16'h0000);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (instr_done) dn++;
        end
        check("st_rst_done", 16'(dn), 16'h0);
        check("st_rst_mem", mem1[16'h0030], 16'h0000);
        check("st_rst_idle_addr", bus.mem_addr, 16'h0000);
        reset = 1'b0;

        // JUMP from RESET_PC FFFF
        poke(1'b1, 16'hFFFF, 16'h9005);
        poke(1'b1, 16'h0005, 16'h7000);
        @(negedge clk);
        reset2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done2("jmp_retire");
        check("jmp_pc", pc2, 16'h0005);

        // Non-jump at FFFF wraps pc to 0000
        @(negedge clk);
        reset2 = 1'b1;
        poke(1'b1, 16'hFFFF, 16'hA000);
        poke(1'b1, 16'h0000, 16'h7000);
        @(negedge clk);
        reset2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done2("wrap_retire");
        check("wrap_pc", pc2, 16'h0000);
        check("wrap_ac", ac2, 16'h0000);
        cyc = 0;
        while (!halted2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("wrap_halted", 16'(halted2), 16'h1);
        check("wrap_halt_pc", pc2, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
